aes_sub_bytes_seq: RTL and testbench

Sequential forward SubBytes engine for the AES-256 encryption datapath, and the encryption-side counterpart of the decryption path's inverse S-box. It accepts a 128-bit AES state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through forward FIPS-197 S-box instances. It then presents the substituted state over a second valid/ready handshake. It sits between the AddRoundKey and ShiftRows stages of the iterative encryption round.

---
 rtl/aes_sub_bytes_seq.sv | 155 +++++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// aes_sub_bytes_seq : sequential forward AES SubBytes, BYTES_PER_CYCLE S-boxes/clk
// Rev 1.0
// ============================================================================
module aes_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_state,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_state,
  output logic         o_busy
);

  localparam int c_N     = 16 / BYTES_PER_CYCLE;
  localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam bit c_LEGAL = (BYTES_PER_CYCLE == 1) || (BYTES_PER_CYCLE == 2) ||
                           (BYTES_PER_CYCLE == 4) || (BYTES_PER_CYCLE == 8) ||
                           (BYTES_PER_CYCLE == 16);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);

  generate
    if (!c_LEGAL) begin : g_bad_cfg
      $error("aes_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    f_sbox = c_SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic [127:0]         r_st;
  logic                 r_idle;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [7:0]           w_bytes    [16];
  logic [7:0]           w_lane_out [BYTES_PER_CYCLE];
  logic [127:0]         w_next_st;

  generate
    for (genvar b = 0; b < 16; b++) begin : g_byte
      assign w_bytes[b] = r_st[127 - 8*b -: 8];
    end

    // Each lane substitutes one byte of the group selected by r_idx.
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
      logic [3:0] w_pos;
      assign w_pos         = 4'(int'(r_idx) * BYTES_PER_CYCLE + g);
      assign w_lane_out[g] = f_sbox(w_bytes[w_pos]);
    end
  endgenerate

  always_comb begin
    w_next_st = r_st;
    for (int k = 0; k < 16; k++) begin
      if ((k / BYTES_PER_CYCLE) == int'(r_idx))
        w_next_st[127 - 8*k -: 8] = w_lane_out[k % BYTES_PER_CYCLE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_st        <= '0;
      r_idle      <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_st    <= i_in_state;
            r_idx   <= '0;
            r_state <= S_SUB;
            r_idle  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SUB: begin
          r_st  <= w_next_st;
          r_idx <= r_idx + c_IDX_W'(1);
          if (r_idx == c_IDX_LAST) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (i_in_valid) begin
              r_st    <= i_in_state;
              r_idx   <= '0;
              r_state <= S_SUB;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_idle  <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idx       <= '0;
          r_idle      <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Back-to-back acceptance in DONE is gated directly by downstream readiness.
  assign o_in_ready  = r_idle | (r_out_valid & i_out_ready);
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_out_state = r_st;

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes_seq.sv
`default_nettype none
// Bench for aes_sub_bytes_seq: five instances (1,2,4,8,16 bytes/cycle) checked
// every cycle against a GF(2^8)-derived S-box model; instance 2 is the default.
module tb_aes_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   iv;
  logic [4:0]   orr;
  logic [127:0] ist [5];
  logic [4:0]   ir;
  logic [4:0]   ov;
  logic [4:0]   bz;
  logic [127:0] st  [5];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 5; g++) begin : g_dut
      aes_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (iv[g]),
        .o_in_ready  (ir[g]),
        .i_in_state  (ist[g]),
        .o_out_valid (ov[g]),
        .i_out_ready (orr[g]),
        .o_out_state (st[g]),
        .o_busy      (bz[g])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_fail   = 0;
  int n_outs   = 0;

  logic [7:0] m_sb  [256];
  logic [7:0] m_isb [256];

  task automatic chk(input string nm, input int inst, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h want %h", nm, inst, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      m_sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int b = 0; b < 256; b++) m_isb[m_sb[b]] = 8'(b);
  endtask

  // First n bytes (FIPS order) substituted, the rest untouched.
  function automatic logic [127:0] part_sub(input logic [127:0] s, input int n);
    logic [127:0] r = s;
    for (int k = 0; k < 16; k++)
      if (k < n) r[127 - 8*k -: 8] = m_sb[s[127 - 8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_all(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = m_isb[s[127 - 8*k -: 8]];
    return r;
  endfunction

  // Behavioural model: phase 0 idle, 1 substituting, 2 result waiting.
  int           m_phase [5];
  int           m_nsub  [5];
  logic [127:0] m_in    [5];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 5; i++) begin
      if (rst) begin
        m_phase[i] <= 0;
        m_nsub[i]  <= 0;
        m_in[i]    <= '0;
      end else begin
        case (m_phase[i])
          0: if (iv[i]) begin
               m_in[i] <= ist[i]; m_nsub[i] <= 0; m_phase[i] <= 1;
             end
          1: begin
               m_nsub[i] <= m_nsub[i] + (1 << i);
               if (m_nsub[i] + (1 << i) >= 16) m_phase[i] <= 2;
             end
          default: if (orr[i]) begin
               if (iv[i]) begin
                 m_in[i] <= ist[i]; m_nsub[i] <= 0; m_phase[i] <= 1;
               end else m_phase[i] <= 0;
             end
        endcase
      end
    end
  end

  logic [127:0] sb_q [$];

  always @(negedge clk) begin
    logic [127:0] e;
    for (int i = 0; i < 5; i++) begin
      chk("in_ready", i, ir[i], (m_phase[i] == 0) || (m_phase[i] == 2 && orr[i]));
      chk("out_valid", i, ov[i], m_phase[i] == 2);
      chk("busy", i, bz[i], m_phase[i] == 1);
      chk("out_state", i, st[i], part_sub(m_in[i], m_nsub[i]));
    end
    if (rst) sb_q.delete();
    else begin
      if (ov[2] && orr[2]) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL stream_order inst2: got output %h, want none (no pending input)", st[2]);
        end else begin
          e = sb_q.pop_front();
          chk("stream_out", 2, st[2], part_sub(e, 16));
          chk("inv_chain", 2, inv_all(st[2]), e);
          n_outs++;
        end
      end
      if (iv[2] && ir[2]) sb_q.push_back(ist[2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int i, input logic [127:0] s, input logic [127:0] exp,
                      input int exp_lat);
    int lat = 0;
    orr[i] = 1'b1;
    while (!ir[i] && lat < 50) begin step(); lat++; end
    iv[i] = 1'b1; ist[i] = s;
    step();
    iv[i] = 1'b0;
    lat = 0;
    while (!ov[i] && lat < 40) begin step(); lat++; end
    chk("latency", i, lat, exp_lat);
    chk("result", i, st[i], exp);
  endtask

  initial begin
    logic [127:0] held, s2;
    int n, acc_n, cyc, outs0;
    bit a;
    rst = 1'b0; iv = '0; orr = '1;
    for (int i = 0; i < 5; i++) ist[i] = '0;
    build_tables();
    chk("model_sbox_00", 0, m_sb[8'h00], 8'h63);
    chk("model_sbox_01", 0, m_sb[8'h01], 8'h7c);
    chk("model_sbox_53", 0, m_sb[8'h53], 8'hed);
    chk("model_sbox_ff", 0, m_sb[8'hff], 8'h16);
    chk("model_fips", 0, part_sub(128'h00102030405060708090a0b0c0d0e0f0, 16),
        128'h63cab7040953d051cd60e0e7ba70e18c);

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset in the middle of a substitution.
    iv[2] = 1'b1; ist[2] = 128'hdeadbeef_01234567_89abcdef_55aa33cc;
    step();
    iv[2] = 1'b0;
    step();
    chk("pre_reset_busy", 2, bz[2], 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 2, ir[2], 1'b1);
    chk("rst_out_valid", 2, ov[2], 1'b0);
    chk("rst_busy", 2, bz[2], 1'b0);
    chk("rst_out_state", 2, st[2], 128'h0);
    step();
    step();
    rst = 1'b0;

    xfer(2, 128'h00102030405060708090a0b0c0d0e0f0, 128'h63cab7040953d051cd60e0e7ba70e18c, 4);

    for (int i = 0; i < 5; i++)
      xfer(i, {4{32'h000153ff}}, {4{32'h637ced16}}, 16 >> i);
    step();

    // Output stall with upstream noise.
    orr[2] = 1'b0; iv[2] = 1'b1; ist[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    step();
    iv[2] = 1'b0;
    n = 0;
    while (!ov[2] && n < 40) begin step(); n++; end
    chk("stall_reach_done", 2, ov[2], 1'b1);
    held = st[2];
    chk("stall_result", 2, held, {4{32'h76727193}} ^ {4{32'h76727193}} ^
        part_sub(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 16));
    for (int c = 0; c < 10; c++) begin
      iv[2] = 1'($urandom % 2);
      ist[2] = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("stall_valid", 2, ov[2], 1'b1);
      chk("stall_state", 2, st[2], held);
      chk("stall_no_accept", 2, bz[2], 1'b0);
    end
    s2 = 128'h112233445566778899aabbccddeeff00;
    iv[2] = 1'b1; ist[2] = s2; orr[2] = 1'b1;
    step();
    iv[2] = 1'b0;
    chk("accept_after_stall_busy", 2, bz[2], 1'b1);
    n = 0;
    while (!ov[2] && n < 40) begin step(); n++; end
    chk("accept_after_stall_result", 2, st[2], part_sub(s2, 16));
    step();

    // Random streaming on the default instance.
    outs0 = n_outs; acc_n = 0; cyc = 0;
    while (acc_n < 100 && cyc < 5000) begin
      @(negedge clk);
      a = iv[2] & ir[2];
      step();
      cyc++;
      if (a) acc_n++;
      if (acc_n >= 100) iv[2] = 1'b0;
      else if (!iv[2] || a) begin
        iv[2] = (($urandom % 4) != 0);
        ist[2] = {$urandom, $urandom, $urandom, $urandom};
      end
      orr[2] = (($urandom % 3) != 0);
    end
    orr[2] = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin step(); n++; end
    step();
    chk("stream_accepted", 2, acc_n, 100);
    chk("stream_drained", 2, sb_q.size(), 0);
    chk("stream_outputs", 2, n_outs - outs0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
